bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, clk cycles per decrement (1 Hz at 100 MHz); legal range 2..2^27-1.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port load  input  1  synchronous load strobe for the digit values.
REQ-005 SHALL have port load_tens  input  4  BCD tens digit to load.
REQ-006 SHALL have port load_ones  input  4  BCD ones digit to load.
REQ-007 SHALL have port start  input  1  start or resume counting.
REQ-008 SHALL have port pause  input  1  suspend counting.
REQ-009 SHALL have port tens  output  4  current BCD tens digit, registered.
REQ-010 SHALL have port ones  output  4  current BCD ones digit, registered.
REQ-011 SHALL have port running  output  1  high only in state RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on expiry, registered.
REQ-013 SHALL have port zero  output  1  combinational; high when tens==0 and ones==0.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, EXPIRED, with a 27-bit prescaler.
REQ-015 In RUN, the prescaler SHALL increment each cycle; at value TICK_DIV-1 it SHALL wrap to 0 and generate a tick at that same edge.
REQ-016 The prescaler SHALL hold in PAUSED, clear on any load, and clear on the IDLE->RUN transition.
REQ-017 On a tick with ones!=0, ones SHALL decrement by 1.
REQ-018 On a tick with ones==0 and tens!=0, ones SHALL become 9 and tens SHALL decrement by 1 (borrow).
REQ-019 The tick that produces 00 SHALL move the state to EXPIRED and set done high for exactly the next cycle.
REQ-020 load SHALL have highest priority in every state: digits take the load values, state goes to IDLE, prescaler clears, and start/pause are ignored that cycle.
REQ-021 Any loaded digit greater than 9 SHALL clamp to 9.
REQ-022 In IDLE, start with a nonzero value SHALL enter RUN; the first decrement SHALL occur TICK_DIV edges after the start edge.
REQ-023 In IDLE, start with value 00 SHALL leave the state in IDLE and SHALL NOT pulse done.
REQ-024 In RUN, pause SHALL enter PAUSED; if start and pause are both high, pause wins.
REQ-025 In PAUSED, start with pause low SHALL return to RUN, keeping the prescaler value; otherwise the state stays PAUSED.
REQ-026 In EXPIRED, digits SHALL hold at 00 and start/pause SHALL be ignored; only load leaves EXPIRED.
REQ-027 A tick SHALL NOT occur in IDLE, PAUSED or EXPIRED, and digits SHALL change only on a tick or a load.

Reset
REQ-028 While reset==0, regardless of clk, the block SHALL force: state IDLE, tens=0, ones=0, prescaler=0, done=0, running=0 (zero therefore 1).
REQ-029 Reset asserted mid-RUN or mid-PAUSED SHALL abandon the count, with no done pulse.
REQ-030 After reset deasserts, the block SHALL stay in IDLE until a load or start.

Verification (bench uses TICK_DIV=4)
REQ-031 Load 2,3, then start -> 23,22,21,20,19, one step every 4 cycles; the 20->19 step shows the borrow (ones 0->9).
REQ-032 Load 0,2, then start -> 00 after 8 cycles; done high exactly 1 cycle; running=0, zero=1; a later start leaves 00 and EXPIRED unchanged.
REQ-033 Running 05, assert pause 2 cycles after a tick, hold 10 cycles, then start -> digits frozen while paused; next decrement 2 cycles after resume.
REQ-034 Load F,A -> 99; load 0,0 then start -> stays IDLE, running=0, no done.
REQ-035 Load 4,7 while RUN at 12 -> next cycle digits 47, state IDLE, running=0; load, start and pause together -> load wins.
REQ-036 Drive reset=0 between clk edges during RUN -> outputs 00, done=0, running=0 immediately, before the next edge.

Source files
------------

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - two-digit BCD countdown timer with prescaler and run/pause/expire control
module bcd_down_timer #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       zero
);

    localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [26:0] presc_q, presc_d;
    logic        done_q, done_d;
    logic        tick;

    // Out-of-range BCD digits saturate at 9 rather than wrapping.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign tick    = (state_q == RUN) && (presc_q == TICK_LAST);
    assign tens    = tens_q;
    assign ones    = ones_q;
    assign done    = done_q;
    assign running = (state_q == RUN);
    assign zero    = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Register all state; reset abandons any count in progress without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            presc_q <= 27'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Next-state, digit and prescaler update; load overrides everything else.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            tens_d  = clamp_digit(load_tens);
            ones_d  = clamp_digit(load_ones);
            presc_d = 27'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !zero) begin
                        state_d = RUN;
                        presc_d = 27'd0;
                    end
                end
                RUN: begin
                    presc_d = tick ? 27'd0 : presc_q + 27'd1;
                    if (pause) begin
                        state_d = PAUSED;
                    end
                    if (tick) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        // Reaching 00 outranks a simultaneous pause.
                        if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - randomized self-checking bench for bcd_down_timer against a seconds-level model
module tb_bcd_down_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       zero;

    int checks = 0;
    int errors = 0;

    // Model: remaining time in whole units, cycles elapsed in current unit, and mode flags.
    int m_val   = 0;
    int m_ph    = 0;
    bit m_run   = 0;
    bit m_pse   = 0;
    bit m_exp   = 0;
    bit m_done  = 0;

    bcd_down_timer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .done      (done),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model, advanced once per rising edge or on reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_val = 0; m_ph = 0; m_run = 0; m_pse = 0; m_exp = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (load) begin
                    m_val = clampd(load_tens) * 10 + clampd(load_ones);
                    m_ph = 0; m_run = 0; m_pse = 0; m_exp = 0;
                end else if (m_exp) begin
                    m_val = 0;
                end else if (m_run && m_pse) begin
                    if (start && !pause) m_pse = 0;
                end else if (m_run) begin
                    if (m_ph == TD - 1) begin
                        m_ph = 0;
                        m_val = m_val - 1;
                        if (m_val == 0) begin
                            m_exp = 1; m_run = 0; m_done = 1;
                        end
                    end else begin
                        m_ph = m_ph + 1;
                    end
                    if (pause && !m_exp) m_pse = 1;
                end else if (start && m_val != 0) begin
                    m_run = 1;
                    m_ph = 0;
                end
            end
        end
    end

    // Compare DUT against model shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cmp_tens", int'(tens), m_val / 10);
            check("cmp_ones", int'(ones), m_val % 10);
            check("cmp_running", int'(running), int'(m_run && !m_pse));
            check("cmp_done", int'(done), int'(m_done));
            check("cmp_zero", int'(zero), int'(m_val == 0));
        end
    end

    task automatic drive(input logic l, input logic [3:0] lt, input logic [3:0] lo,
                         input logic s, input logic p);
        @(negedge clk);
        load = l; load_tens = lt; load_ones = lo; start = s; pause = p;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string name, input int t, input int o, input int r, input int d);
        check({name, "_tens"}, int'(tens), t);
        check({name, "_ones"}, int'(ones), o);
        check({name, "_running"}, int'(running), r);
        check({name, "_done"}, int'(done), d);
    endtask

    initial begin
        idle(3);
        lit("reset", 0, 0, 0, 0);
        check("reset_zero", int'(zero), 1);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        lit("post_reset_idle", 0, 0, 0, 0);

        // Count 23 down through the borrow at 20->19.
        drive(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        lit("c23_loaded", 2, 3, 0, 0);
        idle(1);
        lit("c23_start", 2, 3, 1, 0);
        idle(3);
        lit("c23_before_tick", 2, 3, 1, 0);
        idle(1);
        lit("c23_first", 2, 2, 1, 0);
        idle(8);
        lit("c23_at20", 2, 0, 1, 0);
        idle(4);
        lit("c23_borrow", 1, 9, 1, 0);

        // Expiry from 02 and ignoring start afterwards.
        drive(1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        idle(7);
        lit("exp_at01", 0, 1, 1, 0);
        idle(1);
        lit("exp_hit", 0, 0, 0, 1);
        check("exp_zero", int'(zero), 1);
        idle(1);
        lit("exp_after", 0, 0, 0, 0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(2);
        lit("exp_start_ignored", 0, 0, 0, 0);

        // Pause two cycles after a tick, hold, resume.
        drive(1'b1, 4'd0, 4'd5, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        idle(4);
        lit("pz_tick", 0, 4, 1, 0);
        repeat (10) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        lit("pz_held", 0, 4, 0, 0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        lit("pz_resume", 0, 4, 1, 0);
        idle(1);
        lit("pz_resume1", 0, 4, 1, 0);
        idle(1);
        lit("pz_resume2", 0, 3, 1, 0);

        // Clamp and zero-start.
        drive(1'b1, 4'hF, 4'hA, 1'b0, 1'b0);
        idle(1);
        lit("clamp", 9, 9, 0, 0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        lit("zstart", 0, 0, 0, 0);
        idle(2);
        lit("zstart_later", 0, 0, 0, 0);

        // Load during RUN with start and pause asserted together.
        drive(1'b1, 4'd1, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        idle(4);
        lit("ld_at12", 1, 2, 1, 0);
        drive(1'b1, 4'd4, 4'd7, 1'b1, 1'b1);
        idle(1);
        lit("ld_47", 4, 7, 0, 0);
        idle(5);
        lit("ld_47_idle", 4, 7, 0, 0);

        // Asynchronous reset between edges during RUN.
        drive(1'b1, 4'd2, 4'd5, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(2);
        #2;
        reset = 1'b0;
        #1;
        lit("areset", 0, 0, 0, 0);
        check("areset_zero", int'(zero), 1);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        lit("areset_after", 0, 0, 0, 0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            reset     = (r < 4) ? 1'b0 : 1'b1;
            load      = ($urandom_range(0, 99) < 3);
            load_tens = 4'($urandom_range(0, 15));
            load_ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) load_tens = 4'd0;
            start     = ($urandom_range(0, 99) < 12);
            pause     = ($urandom_range(0, 99) < 6);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
